// File: rtl/i2s_pkg.sv
// i2s_pkg: shared slot type, default frame layout and limits for the I2S receiver
package i2s_pkg;
  localparam int I2S_DATA_SIZE = 24;
  localparam int I2S_MAX_SLOT_BITS = 64;
  typedef enum logic {I2S_LEFT = 1'b0, I2S_RIGHT = 1'b1} i2s_slot_e;
  typedef struct packed {
    logic [I2S_DATA_SIZE-1:0] left;
    logic [I2S_DATA_SIZE-1:0] right;
  } i2s_frame_t;
endpackage

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen: bit-clock divider producing SCK plus rise/fall strobes, idle while disabled or in reset
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int DW = $clog2(CLK_DIV);
  logic          run;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  // strobes fire in the cycle whose closing edge updates sck
  always_comb begin
    run = en && !rst;
    rise_stb = run && div_cnt_q == DW'(CLK_DIV/2-1);
    fall_stb = run && div_cnt_q == DW'(CLK_DIV-1);
    div_cnt_d = (!run || fall_stb) ? '0 : div_cnt_q + DW'(1);
    sck_d = !run ? 1'b0 : rise_stb ? 1'b1 : fall_stb ? 1'b0 : sck_q;
  end
  // divider state
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q <= sck_d;
    end
  end
  assign sck = sck_q;
endmodule

// File: rtl/i2s_stereo_rx.sv
// i2s_stereo_rx: I2S master receiver with valid/ready output; I2S_RX_OVERRUN_CNT_EN adds overrun_cnt
module i2s_stereo_rx
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE = 24,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i2s_sd,
  output logic                 i2s_sck,
  output logic                 i2s_ws,
  output logic [DATA_SIZE-1:0] out_left,
  output logic [DATA_SIZE-1:0] out_right,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef I2S_RX_OVERRUN_CNT_EN
  ,
  output logic [15:0]          overrun_cnt
`endif
);
  localparam int BW = $clog2(2*SLOT_BITS);
  logic                 rise_stb, fall_stb;
  logic [BW-1:0]        bit_idx_q, bit_idx_d, pos;
  i2s_slot_e            ws_q, ws_d;
  logic [DATA_SIZE-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d, right_word;
  logic [DATA_SIZE-1:0] out_left_q, out_left_d, out_right_q, out_right_d;
  logic                 out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                 cap, complete, load, drop;
  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk(clk), .rst(rst), .en(en), .sck(i2s_sck), .rise_stb(rise_stb), .fall_stb(fall_stb)
  );
  // bit position, slot capture (position 0 is the Philips one-bit delay) and output handshake
  always_comb begin
    pos = (ws_q == I2S_RIGHT) ? bit_idx_q - BW'(SLOT_BITS) : bit_idx_q;
    cap = rise_stb && pos != '0 && pos <= BW'(DATA_SIZE);
    bit_idx_d = !en ? '0 : !fall_stb ? bit_idx_q : (bit_idx_q == BW'(2*SLOT_BITS-1)) ? '0 : bit_idx_q + BW'(1);
    ws_d = i2s_slot_e'(bit_idx_d >= BW'(SLOT_BITS));
    right_word = {right_sr_q[DATA_SIZE-2:0], i2s_sd};
    left_sr_d = (cap && ws_q == I2S_LEFT) ? {left_sr_q[DATA_SIZE-2:0], i2s_sd} : left_sr_q;
    right_sr_d = (cap && ws_q == I2S_RIGHT) ? right_word : right_sr_q;
    complete = cap && ws_q == I2S_RIGHT && pos == BW'(DATA_SIZE);
    load = complete && (!out_valid_q || out_ready);
    drop = complete && out_valid_q && !out_ready;
    out_left_d = load ? left_sr_q : out_left_q;
    out_right_d = load ? right_word : out_right_q;
    out_valid_d = load || (out_valid_q && !out_ready);
    overrun_d = drop || (overrun_q && !overrun_clr);
  end
  // receiver state
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q <= '0;
      ws_q <= I2S_LEFT;
      left_sr_q <= '0;
      right_sr_q <= '0;
      out_left_q <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bit_idx_q <= bit_idx_d;
      ws_q <= ws_d;
      left_sr_q <= left_sr_d;
      right_sr_q <= right_sr_d;
      out_left_q <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q <= overrun_d;
    end
  end
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  // saturating dropped-frame count; a drop in the clear cycle still counts
  always_comb cnt_d = drop ? ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1) : overrun_clr ? 16'd0 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? 16'd0 : cnt_d;
  assign overrun_cnt = cnt_q;
`endif
  assign i2s_ws = ws_q;
  assign out_left = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_i2s_stereo_rx.sv
// tb_i2s_stereo_rx: scoreboard bench for i2s_stereo_rx (24/32/4 build plus a 15/16/2 build)
`timescale 1ns/1ps
module tb_i2s_stereo_rx;
  localparam int DS = 24;
  localparam int DS2 = 15;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, i2s_sd = 1'b0, out_ready = 1'b1, overrun_clr = 1'b0;
  logic i2s_sck, i2s_ws, out_valid, overrun;
  logic [DS-1:0] out_left, out_right;
  logic en2 = 1'b0, sd2 = 1'b0;
  logic sck2, ws2, valid2, overrun2;
  logic [DS2-1:0] left2, right2;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt, overrun_cnt2;
`endif
  int n_tests = 0, n_fail = 0;
  logic [2*DS-1:0] sb_q[$];
  int last_cnt = 0, acc_cnt = 0, frame_no = 0;
  int pos = 0, pos2 = 0;
  logic ws_prev = 1'b0, ws2_prev = 1'b0, prev_sck = 1'b0, prev_sck2 = 1'b0;
  logic [DS-1:0] cur_l = '0, cur_r = '0;
  logic [DS2-1:0] l2 = 15'h7FFF, r2 = 15'h0001;

  always #5 clk = ~clk;

  i2s_stereo_rx #(.DATA_SIZE(DS), .SLOT_BITS(32), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .i2s_sd(i2s_sd), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef I2S_RX_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  i2s_stereo_rx #(.DATA_SIZE(DS2), .SLOT_BITS(16), .CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .i2s_sd(sd2), .i2s_sck(sck2), .i2s_ws(ws2),
    .out_left(left2), .out_right(right2), .out_valid(valid2), .out_ready(1'b1),
    .overrun(overrun2), .overrun_clr(1'b0)
`ifdef I2S_RX_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // microphone models and output monitor, all on the falling clk edge
  always @(negedge clk) begin
    logic [2*DS-1:0] exp;
    if (out_valid && out_ready && !rst) begin
      acc_cnt++;
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
      chk("pair", {out_left, out_right}, exp);
    end
    if (rst || !en) begin
      pos = 0;
      ws_prev = 1'b0;
    end else if (prev_sck && !i2s_sck) begin
      pos = (i2s_ws != ws_prev) ? 0 : pos + 1;
      ws_prev = i2s_ws;
      if (!i2s_ws && pos == 1) begin
        cur_l = (frame_no == 0) ? 24'hA5A5A5 : DS'($urandom);
        cur_r = (frame_no == 0) ? 24'h123456 : DS'($urandom);
        frame_no++;
        sb_q.push_back({cur_l, cur_r});
      end
      i2s_sd = (pos >= 1 && pos <= DS) ? (i2s_ws ? cur_r[DS-pos] : cur_l[DS-pos]) : 1'b1;
      if (i2s_ws && pos == DS) last_cnt++;
    end
    prev_sck = i2s_sck;
    if (rst || !en2) begin
      pos2 = 0;
      ws2_prev = 1'b0;
    end else if (prev_sck2 && !sck2) begin
      pos2 = (ws2 != ws2_prev) ? 0 : pos2 + 1;
      ws2_prev = ws2;
      sd2 = (pos2 >= 1 && pos2 <= DS2) ? (ws2 ? r2[DS2-pos2] : l2[DS2-pos2]) : 1'b1;
    end
    prev_sck2 = sck2;
  end

  // returns at the first posedge after the model drove the last right-slot data bit
  task automatic wait_last();
    int n0 = last_cnt;
    int c = 0;
    while (last_cnt == n0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    chk("last_bit_seen", 64'(last_cnt != n0), 1);
  endtask

  task automatic slot_len(input logic lvl, output int falls, output int per);
    int cyc = 0, r0 = -1;
    logic p = i2s_sck;
    falls = 0;
    per = 0;
    while (i2s_ws == lvl && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!p && i2s_sck) begin
        if (r0 >= 0 && per == 0) per = cyc - r0;
        r0 = cyc;
      end
      if (p && !i2s_sck) falls++;
      p = i2s_sck;
    end
  endtask

  initial begin
    int falls, per, cyc, a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", i2s_sck, 0);
    chk("rst_ws", i2s_ws, 0);
    chk("rst_left", out_left, 0);
    chk("rst_right", out_right, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("rst_cnt", overrun_cnt, 0);
`endif
    rst = 1'b0;
    en2 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      @(posedge clk);
      #1;
      while (!valid2 && cyc < 500) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("cfg2_valid", valid2, 1);
      chk("cfg2_pair", {left2, right2}, {15'h7FFF, 15'h0001});
    end
    en2 = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1;
    slot_len(1'b0, falls, per);
    chk("sck_period", per, 4);
    chk("first_left_len", falls, 32);
    wait_last();
    #1;
    chk("valid_before_latency", out_valid, 0);
    @(posedge clk);
    #1;
    chk("valid_after_latency", out_valid, 1);
    chk("left_a5", out_left, 24'hA5A5A5);
    chk("right_123456", out_right, 24'h123456);
    @(posedge clk);
    #1;
    chk("valid_one_clk", out_valid, 0);
    slot_len(1'b1, falls, per);
    slot_len(1'b0, falls, per);
    chk("left_len", falls, 32);
    slot_len(1'b1, falls, per);
    chk("right_len", falls, 32);
    out_ready = 1'b0;
    repeat (3) wait_last();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid", out_valid, 1);
    chk("bp_hold", {out_left, out_right}, sb_q[0]);
    chk("bp_overrun", overrun, 1);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("bp_cnt", overrun_cnt, 2);
`endif
    overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    chk("cnt_clr", overrun_cnt, 0);
`endif
    sb_q.delete(1);
    sb_q.delete(1);
    a0 = acc_cnt;
    out_ready = 1'b1;
    wait_last();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_accepts", acc_cnt - a0, 2);
    chk("bp_drained", sb_q.size(), 0);
    out_ready = 1'b0;
    wait_last();
    wait_last();
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sim_valid", out_valid, 1);
    chk("sim_pair", {out_left, out_right}, sb_q[0]);
    chk("sim_overrun", overrun, 0);
    out_ready = 1'b1;
    slot_len(1'b1, falls, per);
    slot_len(1'b0, falls, per);
    repeat (40) @(posedge clk);
    #1;
    en = 1'b0;
    a0 = acc_cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("dis_sck", i2s_sck, 0);
    chk("dis_ws", i2s_ws, 0);
    void'(sb_q.pop_back());
    repeat (20) @(posedge clk);
    #1;
    en = 1'b1;
    wait_last();
    repeat (3) @(posedge clk);
    #1;
    chk("en_accepts", acc_cnt - a0, 1);
    chk("en_drained", sb_q.size(), 0);
    repeat (60) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_left", out_left, 0);
    chk("mrst_sck", i2s_sck, 0);
    chk("mrst_ws", i2s_ws, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    a0 = acc_cnt;
    wait_last();
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_accepts", acc_cnt - a0, 1);
    chk("mrst_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
